// File: rtl/_ureg_rs_pkg.sv
// Shared constants for the universal register: mode encodings and mode width.
package _ureg_rs_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'd1;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'd2;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'd3;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'd4;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'd5;
    localparam logic [MODE_W-1:0] MODE_INC  = 3'd6;
    localparam logic [MODE_W-1:0] MODE_DEC  = 3'd7;

endpackage

// File: rtl/_dff.sv
// Plain WIDTH-bit D register with synchronous active-high reset to RST_VAL.
module _dff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= RST_VAL;
        else
            q <= d;
    end

endmodule

// File: rtl/_ureg_next.sv
// Combinational next-state selection for the universal register, one entry per mode.
module _ureg_next
    import _ureg_rs_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]  q,
    input  logic [WIDTH-1:0]  d,
    input  logic              si,
    input  logic              so_cur,
    input  logic [MODE_W-1:0] mode,
    output logic [WIDTH-1:0]  q_nxt,
    output logic              so_nxt,
    output logic              co_nxt
);

    always_comb begin
        q_nxt  = q;
        so_nxt = so_cur;
        co_nxt = 1'b0;
        case (mode)
            MODE_HOLD: q_nxt = q;
            MODE_LOAD: q_nxt = d;
            MODE_SHL: begin
                q_nxt  = {q[WIDTH-2:0], si};
                so_nxt = q[WIDTH-1];
            end
            MODE_SHR: begin
                q_nxt  = {si, q[WIDTH-1:1]};
                so_nxt = q[0];
            end
            MODE_ROL: begin
                q_nxt  = {q[WIDTH-2:0], q[WIDTH-1]};
                so_nxt = q[WIDTH-1];
            end
            MODE_ROR: begin
                q_nxt  = {q[0], q[WIDTH-1:1]};
                so_nxt = q[0];
            end
            MODE_INC: begin
                q_nxt  = q + 1'b1;
                co_nxt = &q;
            end
            MODE_DEC: begin
                q_nxt  = q - 1'b1;
                co_nxt = ~|q;
            end
            default: q_nxt = q;
        endcase
    end

endmodule

// File: rtl/_ureg_rs.sv
// Universal WIDTH-bit register: reset > set > clr > hold > mode operation.
// Optional zero flag output zf is built when UREG_ZERO_FLAG_EN is defined.
module _ureg_rs
    import _ureg_rs_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [WIDTH-1:0] SET_VAL   = '1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set,
    input  logic              clr,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  d,
    input  logic              si,
    output logic [WIDTH-1:0]  q,
`ifdef UREG_ZERO_FLAG_EN
    output logic              zf,
`endif
    output logic              so,
    output logic              co
);

    logic [WIDTH-1:0] op_q;
    logic             op_so;
    logic             op_co;
    logic [WIDTH-1:0] q_d;
    logic             so_d;
    logic             co_d;

    _ureg_next #(.WIDTH(WIDTH)) u_next (
        .q      (q),
        .d      (d),
        .si     (si),
        .so_cur (so),
        .mode   (mode),
        .q_nxt  (op_q),
        .so_nxt (op_so),
        .co_nxt (op_co)
    );

    // reset is applied inside the registers; everything below it is priority muxing
    always_comb begin
        q_d  = op_q;
        so_d = op_so;
        co_d = op_co;
        if (set) begin
            q_d  = SET_VAL;
            so_d = 1'b0;
            co_d = 1'b0;
        end else if (clr) begin
            q_d  = '0;
            so_d = 1'b0;
            co_d = 1'b0;
        end else if (!en) begin
            q_d  = q;
            so_d = so;
            co_d = co;
        end
    end

    _dff #(.WIDTH(WIDTH), .RST_VAL(RESET_VAL)) u_q_reg (
        .clk   (clk),
        .reset (reset),
        .d     (q_d),
        .q     (q)
    );

    _dff #(.WIDTH(2), .RST_VAL(2'b00)) u_flag_reg (
        .clk   (clk),
        .reset (reset),
        .d     ({so_d, co_d}),
        .q     ({so, co})
    );

`ifdef UREG_ZERO_FLAG_EN
    _dff #(.WIDTH(1), .RST_VAL(RESET_VAL == '0)) u_zf_reg (
        .clk   (clk),
        .reset (reset),
        .d     (q_d == '0),
        .q     (zf)
    );
`endif

endmodule

// File: tb/tb__ureg_rs.sv
// Directed bench for _ureg_rs (WIDTH=8) with hand-computed expectations.
module tb__ureg_rs;
    import _ureg_rs_pkg::*;

    logic              clk = 1'b0;
    logic              reset, set, clr, en, si;
    logic [MODE_W-1:0] mode;
    logic [7:0]        d;
    logic [7:0]        q;
    logic              so, co;
`ifdef UREG_ZERO_FLAG_EN
    logic              zf;
`endif

    int checks = 0;
    int errors = 0;

    _ureg_rs #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .set   (set),
        .clr   (clr),
        .en    (en),
        .mode  (mode),
        .d     (d),
        .si    (si),
        .q     (q),
`ifdef UREG_ZERO_FLAG_EN
        .zf    (zf),
`endif
        .so    (so),
        .co    (co)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // drive controls away from the edge, clock once, then sample 1 time unit later
    task automatic step(input logic r, input logic s, input logic c, input logic e,
                        input logic [MODE_W-1:0] m, input logic [7:0] dv, input logic sv);
        @(negedge clk);
        reset = r; set = s; clr = c; en = e; mode = m; d = dv; si = sv;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic [7:0] eq, input logic eso, input logic eco);
        chk({tag, ".q"},  {24'd0, q},  {24'd0, eq});
        chk({tag, ".so"}, {31'd0, so}, {31'd0, eso});
        chk({tag, ".co"}, {31'd0, co}, {31'd0, eco});
    endtask

    initial begin
        reset = 1'b1; set = 1'b0; clr = 1'b0; en = 1'b0;
        mode = MODE_HOLD; d = 8'h00; si = 1'b0;

        step(1, 0, 0, 0, MODE_HOLD, 8'h00, 0); expect_all("reset", 8'h00, 0, 0);
`ifdef UREG_ZERO_FLAG_EN
        chk("reset.zf", {31'd0, zf}, 32'd1);
`endif
        step(0, 1, 1, 1, MODE_LOAD, 8'h12, 0); expect_all("set_over_clr", 8'hFF, 0, 0);
        step(1, 1, 0, 0, MODE_HOLD, 8'h00, 0); expect_all("reset_over_set", 8'h00, 0, 0);

        step(0, 0, 0, 1, MODE_LOAD, 8'hA5, 0); expect_all("load_a5", 8'hA5, 0, 0);
        step(0, 0, 0, 1, MODE_SHL,  8'h00, 1); expect_all("shl", 8'h4B, 1, 0);
        step(0, 0, 0, 1, MODE_SHR,  8'h00, 0); expect_all("shr", 8'h25, 1, 0);

        step(0, 0, 0, 1, MODE_LOAD, 8'h81, 0); expect_all("load_81", 8'h81, 1, 0);
        step(0, 0, 0, 1, MODE_ROL,  8'h00, 0); expect_all("rol", 8'h03, 1, 0);
        step(0, 0, 0, 1, MODE_ROR,  8'h00, 0); expect_all("ror", 8'h81, 1, 0);

        step(0, 0, 0, 1, MODE_LOAD, 8'hFE, 0); expect_all("load_fe", 8'hFE, 1, 0);
        step(0, 0, 0, 1, MODE_INC,  8'h00, 0); expect_all("inc1", 8'hFF, 1, 0);
        step(0, 0, 0, 1, MODE_INC,  8'h00, 0); expect_all("inc_wrap", 8'h00, 1, 1);
        step(0, 0, 0, 1, MODE_DEC,  8'h00, 0); expect_all("dec_wrap", 8'hFF, 1, 1);
        step(0, 0, 0, 1, MODE_HOLD, 8'h00, 0); expect_all("hold_co_clr", 8'hFF, 1, 0);

        step(0, 0, 0, 1, MODE_INC,  8'h00, 0); expect_all("inc_wrap2", 8'h00, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, MODE_INC, 8'h5A, 1);
            expect_all($sformatf("en0_hold%0d", i), 8'h00, 1, 1);
        end

        step(0, 0, 1, 1, MODE_LOAD, 8'h77, 1); expect_all("clr_over_load", 8'h00, 0, 0);

        step(0, 0, 0, 1, MODE_INC,  8'h00, 0); expect_all("run_inc1", 8'h01, 0, 0);
        step(0, 0, 0, 1, MODE_INC,  8'h00, 0); expect_all("run_inc2", 8'h02, 0, 0);
        step(1, 0, 0, 1, MODE_INC,  8'h00, 0); expect_all("reset_mid_run", 8'h00, 0, 0);
        step(0, 0, 0, 1, MODE_HOLD, 8'h00, 0); expect_all("after_reset", 8'h00, 0, 0);

`ifdef UREG_ZERO_FLAG_EN
        step(0, 0, 0, 1, MODE_LOAD, 8'h01, 0); chk("zf_load1", {31'd0, zf}, 32'd0);
        step(0, 0, 0, 1, MODE_DEC,  8'h00, 0); chk("zf_dec",   {31'd0, zf}, 32'd1);
        step(0, 0, 0, 1, MODE_INC,  8'h00, 0); chk("zf_inc",   {31'd0, zf}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
